// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types and constants used by the fetch stage and its neighbours.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013; // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic        valid_if_id;
    } if_id_reg_t;

    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry output buffer of the fetch stage; drives the IF/ID register input directly.
// Priority: invalidate > load > consume.
module fetch_buf
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    input  logic        consume,
    input  logic        invalidate,
    output if_id_reg_t  out
);

    // NOTE: emptying only swaps in a NOP and drops valid; the pc fields keep their last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '{pc: '0, instruction: NOP_INSTR, pc_plus4: '0, valid_if_id: 1'b0};
        end else if (invalidate || (consume && !load)) begin
            out.instruction <= NOP_INSTR;
            out.valid_if_id <= 1'b0;
        end else if (load) begin
            out <= '{pc:          load_pc,
                     instruction: load_instr,
                     pc_plus4:    load_pc + 32'd4,
                     valid_if_id: 1'b1};
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM and IF/ID output buffer.
// Define IF_MISALIGN_CHECK_EN to trap misaligned redirect targets in FS_FAULT.
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output if_id_reg_t      out,
    output logic            fetch_misaligned
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_req;
    logic [XLEN-1:0] target;
    logic            kill;
    logic            redirect_bad;
    logic            req_fire;
    logic            consume;
    logic            load;
    logic            pending;

`ifdef IF_MISALIGN_CHECK_EN
    assign target           = redirect_pc;
    assign redirect_bad     = |redirect_pc[1:0];
    assign fetch_misaligned = (state == FS_FAULT);
`else
    assign target           = redirect_pc & ~XLEN'(3);
    assign redirect_bad     = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    // A request may go out while the buffer drains this cycle, since the response is at least a cycle away.
    assign consume        = out.valid_if_id && !stall;
    assign imem_req_valid = !reset && (state == FS_REQ) && (!out.valid_if_id || !stall);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign load           = (state == FS_WAIT) && imem_resp_valid && !kill && !redirect_valid;

    // A request is still in flight after this edge; a redirect must mark it stale.
    assign pending = ((state == FS_REQ)   && req_fire) ||
                     ((state == FS_WAIT)  && !imem_resp_valid) ||
                     ((state == FS_FAULT) && kill && !imem_resp_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FS_REQ;
            pc     <= RESET_PC;
            pc_req <= RESET_PC;
            kill   <= 1'b0;
        end else if (redirect_valid) begin
            pc    <= target;
            kill  <= pending;
            state <= redirect_bad ? FS_FAULT : (pending ? FS_WAIT : FS_REQ);
        end else begin
            case (state)
                FS_REQ: begin
                    if (req_fire) begin
                        pc_req <= pc;
                        state  <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (imem_resp_valid) begin
                        if (kill) kill <= 1'b0;
                        else      pc   <= pc_req + XLEN'(4);
                        state <= FS_REQ;
                    end
                end
`ifdef IF_MISALIGN_CHECK_EN
                FS_FAULT: begin
                    if (imem_resp_valid) kill <= 1'b0;
                end
`endif
                default: state <= FS_REQ;
            endcase
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_pc    (32'(pc_req)),
        .load_instr (imem_resp_data),
        .consume    (consume),
        .invalidate (redirect_valid),
        .out        (out)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed phases, request and output monitors.
module tb_if_fetch_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    if_id_reg_t  dut_out;
    logic        fetch_misaligned;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          resp_delay = 1;

    logic [31:0] exp_req[$];
    if_id_reg_t  exp_out[$];

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .out              (dut_out),
        .fetch_misaligned (fetch_misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h00A0_0093;
            32'h0000_0104: return 32'h0010_8113;
            32'h0000_0200: return 32'h0050_0193;
            32'h0000_0300: return 32'h0000_0213;
            32'hFFFF_FFFC: return 32'h0000_006F;
            default:       return {16'hBAD0, a[15:0]};
        endcase
    endfunction

    task automatic push_out(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4);
        exp_out.push_back('{pc: pc, instruction: instr, pc_plus4: pc4, valid_if_id: 1'b1});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory: answers each accepted request resp_delay edges after acceptance.
    initial begin
        logic [31:0] a;
        int          d;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset && imem_req_valid && imem_req_ready) begin
                a = imem_req_addr;
                d = resp_delay;
                @(posedge clk);
                repeat (d - 1) @(posedge clk);
                #1;
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(a);
                @(posedge clk);
                #1;
                imem_resp_valid = 1'b0;
            end
        end
    end

    // Request monitor: every accepted request must match the next expected address.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && imem_req_valid && imem_req_ready) begin
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got %h, expected none (t=%0t)", imem_req_addr, $time);
                end else begin
                    check("req_addr", imem_req_addr, exp_req.pop_front());
                end
            end
        end
    end

    // Output monitor: a valid buffer must match the queue head; it is retired when not stalled.
    initial begin
        if_id_reg_t e;
        forever begin
            @(negedge clk);
            if (!reset && dut_out.valid_if_id) begin
                if (exp_out.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got pc=%h instr=%h, expected none (t=%0t)",
                             dut_out.pc, dut_out.instruction, $time);
                end else begin
                    e = exp_out[0];
                    check("out_pc", dut_out.pc, e.pc);
                    check("out_instr", dut_out.instruction, e.instruction);
                    check("out_pc_plus4", dut_out.pc_plus4, e.pc_plus4);
                    if (!stall) void'(exp_out.pop_front());
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_pc", dut_out.pc, 32'h0);
        check("rst_out_instr", dut_out.instruction, 32'h0000_0013);
        check("rst_out_pc_plus4", dut_out.pc_plus4, 32'h0);
        check("rst_out_valid", 32'(dut_out.valid_if_id), 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0000_0100);
        check("rst_misaligned", 32'(fetch_misaligned), 32'h0);

        // Reset release, then a 3-cycle stall while the first instruction sits in the buffer.
        exp_req.push_back(32'h0000_0100);
        exp_req.push_back(32'h0000_0104);
        push_out(32'h0000_0100, 32'h00A0_0093, 32'h0000_0104);
        push_out(32'h0000_0104, 32'h0010_8113, 32'h0000_0108);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("c0_req_valid", 32'(imem_req_valid), 32'h1);
        check("c0_req_addr", imem_req_addr, 32'h0000_0100);
        step(); #1;
        check("c1_req_valid", 32'(imem_req_valid), 32'h0);
        step(); stall = 1'b1; #1;
        check("c2_out_valid", 32'(dut_out.valid_if_id), 32'h1);
        check("c2_out_pc_plus4", dut_out.pc_plus4, 32'h0000_0104);
        check("c2_stall_no_req", 32'(imem_req_valid), 32'h0);
        step(); #1;
        check("c3_stall_no_req", 32'(imem_req_valid), 32'h0);
        step(); #1;
        check("c4_stall_no_req", 32'(imem_req_valid), 32'h0);
        step(); stall = 1'b0; #1;
        check("c5_req_valid", 32'(imem_req_valid), 32'h1);
        check("c5_req_addr", imem_req_addr, 32'h0000_0104);
        step();
        step(); imem_req_ready = 1'b0; #1;
        check("c7_out_pc", dut_out.pc, 32'h0000_0104);
        step(); #1;
        check("c8_parked_addr", imem_req_addr, 32'h0000_0108);
        check("c8_out_empty", 32'(dut_out.valid_if_id), 32'h0);

        // Redirect while waiting; the response for 0x108 arrives later and must be dropped.
        exp_req.push_back(32'h0000_0108);
        resp_delay     = 2;
        imem_req_ready = 1'b1;
        step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
        check("p1_wait_no_req", 32'(imem_req_valid), 32'h0);
        step(); redirect_valid = 1'b0; #1;
        check("p2_out_valid", 32'(dut_out.valid_if_id), 32'h0);
        check("p2_req_valid", 32'(imem_req_valid), 32'h0);
        exp_req.push_back(32'h0000_0200);
        push_out(32'h0000_0200, 32'h0050_0193, 32'h0000_0204);
        step(); #1;
        check("p3_out_valid", 32'(dut_out.valid_if_id), 32'h0);
        check("p3_req_valid", 32'(imem_req_valid), 32'h1);
        check("p3_req_addr", imem_req_addr, 32'h0000_0200);
        step();
        step();
        step(); imem_req_ready = 1'b0; resp_delay = 1; #1;
        check("p6_out_pc", dut_out.pc, 32'h0000_0200);

        // Redirect in the same cycle as a request handshake.
        step(); #1;
        check("q0_parked_addr", imem_req_addr, 32'h0000_0204);
        check("q0_out_empty", 32'(dut_out.valid_if_id), 32'h0);
        exp_req.push_back(32'h0000_0204);
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step(); redirect_valid = 1'b0; #1;
        check("q1_req_valid", 32'(imem_req_valid), 32'h0);
        step(); #1;
        check("q2_req_addr", imem_req_addr, 32'h0000_0300);
        check("q2_out_valid", 32'(dut_out.valid_if_id), 32'h0);
        exp_req.push_back(32'h0000_0300);

        // Redirect in the same cycle as the response.
        step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; #1;
        check("q3_req_valid", 32'(imem_req_valid), 32'h0);
        step(); redirect_valid = 1'b0; imem_req_ready = 1'b0; #1;
        check("q4_req_valid", 32'(imem_req_valid), 32'h1);
        check("q4_req_addr", imem_req_addr, 32'h0000_0400);
        check("q4_out_valid", 32'(dut_out.valid_if_id), 32'h0);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step(); redirect_valid = 1'b0; #1;
        check("r1_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        exp_req.push_back(32'hFFFF_FFFC);
        push_out(32'hFFFF_FFFC, 32'h0000_006F, 32'h0000_0000);
        imem_req_ready = 1'b1;
        step(); imem_req_ready = 1'b0; #1;
        check("r2_req_valid", 32'(imem_req_valid), 32'h0);
        step(); #1;
        check("r3_out_valid", 32'(dut_out.valid_if_id), 32'h1);
        check("r3_out_pc_plus4", dut_out.pc_plus4, 32'h0000_0000);
        check("r3_req_addr", imem_req_addr, 32'h0000_0000);

        // Misaligned redirect target.
        step(); #1;
        check("f0_out_valid", 32'(dut_out.valid_if_id), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        step(); redirect_valid = 1'b0; #1;
`ifdef IF_MISALIGN_CHECK_EN
        check("f1_misaligned", 32'(fetch_misaligned), 32'h1);
        check("f1_req_valid", 32'(imem_req_valid), 32'h0);
`else
        check("f1_misaligned", 32'(fetch_misaligned), 32'h0);
        check("f1_req_valid", 32'(imem_req_valid), 32'h1);
        check("f1_req_addr", imem_req_addr, 32'h0000_0200);
`endif
        check("f1_out_valid", 32'(dut_out.valid_if_id), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step(); redirect_valid = 1'b0; #1;
        check("f3_misaligned", 32'(fetch_misaligned), 32'h0);
        check("f3_req_valid", 32'(imem_req_valid), 32'h1);
        check("f3_req_addr", imem_req_addr, 32'h0000_0300);
        exp_req.push_back(32'h0000_0300);
        push_out(32'h0000_0300, 32'h0000_0213, 32'h0000_0304);
        imem_req_ready = 1'b1;
        step(); imem_req_ready = 1'b0; #1;
        step(); #1;
        check("f5_out_valid", 32'(dut_out.valid_if_id), 32'h1);
        step(); #1;
        check("f6_out_valid", 32'(dut_out.valid_if_id), 32'h0);

        repeat (3) step();
        check("exp_req_drained", 32'(exp_req.size()), 32'h0);
        check("exp_out_drained", 32'(exp_out.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
